// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the register file with
// pending scoreboard (regfile_sb, rf_scoreboard).
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int ZERO_REG  = 0;

   // Width of a counter able to hold the values 0..n inclusive.
   function automatic int clog2_cnt(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending bits, issue handshake, flush and the
// registered pending count. Register 0 is never pending.
// Optional feature: REGFILE_BYPASS_EN makes a same-cycle writeback clear the
// pending bit seen by the read ports.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter  int NREGS = NREGS_DEF,
   parameter  int NRD   = 2,
   localparam int AW    = $clog2(NREGS),
   localparam int CW    = clog2_cnt(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD-1:0]    rd_pend,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic              iss_valid,
   input  logic [AW-1:0]     iss_addr,
   output logic              iss_ready,
   input  logic              flush,
   output logic [CW-1:0]     pend_cnt
);

   localparam logic [AW-1:0] ZA = AW'(ZERO_REG);

   logic [NREGS-1:0] pend;
   logic [NREGS-1:0] pend_nxt;
   logic             clr;
   logic             set;
   logic             inc;
   logic             dec;

   // Issue may proceed if the destination is free, being written back now, or x0.
   always_comb begin
      iss_ready = ~pend[iss_addr] | (wr_en & (wr_addr == iss_addr)) | (iss_addr == ZA);
   end

   // Count bookkeeping: a set only adds when the bit was clear; a clear only
   // subtracts when it is not immediately re-set by an issue to the same register.
   always_comb begin
      clr = wr_en & (wr_addr != ZA);
      set = iss_valid & iss_ready & ~flush & (iss_addr != ZA);
      inc = set & ~pend[iss_addr];
      dec = clr & pend[wr_addr] & ~(set & (iss_addr == wr_addr));
   end

   // Next pending vector: clear on writeback, set wins over clear, flush wipes all.
   always_comb begin
      pend_nxt = pend;
      if (clr) pend_nxt[wr_addr] = 1'b0;
      if (set) pend_nxt[iss_addr] = 1'b1;
      if (flush) pend_nxt = '0;
      pend_nxt[ZERO_REG] = 1'b0;
   end

   // Pending state and count registers; reset overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend     <= '0;
         pend_cnt <= '0;
      end else begin
         pend <= pend_nxt;
         if (flush) pend_cnt <= '0;
         else       pend_cnt <= pend_cnt + CW'(inc) - CW'(dec);
      end
   end

   // Per-port pending lookup, optionally seeing a same-cycle writeback as cleared.
   always_comb begin
      rd_pend = '0;
      for (int k = 0; k < NRD; k++) begin
         logic [AW-1:0] a;
         a = rd_addr[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
         if (wr_en && (wr_addr == a)) rd_pend[k] = 1'b0;
         else                         rd_pend[k] = (a != ZA) & pend[a];
`else
         rd_pend[k] = (a != ZA) & pend[a];
`endif
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with x0 hardwired to zero,
// NRD combinational read ports and a per-register pending scoreboard.
// Optional feature: REGFILE_BYPASS_EN enables write-through of the current
// writeback to the read ports (data and pending bit).
module regfile_sb
   import regfile_pkg::*;
#(
   parameter  int XLEN  = XLEN_DEF,
   parameter  int NREGS = NREGS_DEF,
   parameter  int NRD   = 2,
   localparam int AW    = $clog2(NREGS),
   localparam int CW    = clog2_cnt(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_pend,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [XLEN-1:0]     wr_data,
   input  logic                iss_valid,
   input  logic [AW-1:0]       iss_addr,
   output logic                iss_ready,
   input  logic                flush,
   output logic [CW-1:0]       pend_cnt
);

   localparam logic [AW-1:0] ZA = AW'(ZERO_REG);

   logic [XLEN-1:0] regs [NREGS];

   // Data array: reset clears every entry, writes to x0 are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_en && (wr_addr != ZA)) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Read muxes: x0 reads as zero; optional write-through of the writeback.
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < NRD; k++) begin
         logic [AW-1:0] a;
         a = rd_addr[k*AW +: AW];
         if (a == ZA)
            rd_data[k*XLEN +: XLEN] = '0;
`ifdef REGFILE_BYPASS_EN
         else if (wr_en && (wr_addr == a))
            rd_data[k*XLEN +: XLEN] = wr_data;
`endif
         else
            rd_data[k*XLEN +: XLEN] = regs[a];
      end
   end

   rf_scoreboard #(
      .NREGS (NREGS),
      .NRD   (NRD)
   ) u_sb (
      .clk       (clk),
      .rst       (rst),
      .rd_addr   (rd_addr),
      .rd_pend   (rd_pend),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .iss_valid (iss_valid),
      .iss_addr  (iss_addr),
      .iss_ready (iss_ready),
      .flush     (flush),
      .pend_cnt  (pend_cnt)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and random stimulus against a behavioural model of
// the register file; expectations are queued by the driver and checked by an
// independent monitor on the falling clock edge.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_pend;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        iss_valid;
   logic [4:0]  iss_addr;
   logic        iss_ready;
   logic        flush;
   logic [5:0]  pend_cnt;

   regfile_sb dut (
      .clk       (clk),
      .rst       (rst),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_pend   (rd_pend),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .iss_valid (iss_valid),
      .iss_addr  (iss_addr),
      .iss_ready (iss_ready),
      .flush     (flush),
      .pend_cnt  (pend_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0]  p;
      logic        rdy;
      logic [5:0]  cnt;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state: architectural contents and the set of pending registers.
   logic [31:0] mem [32];
   bit          pnd [32];

   function automatic logic [31:0] m_data(input int a, input bit we, input int wa, input logic [31:0] wd);
      if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
      if (we && wa == a) return wd;
`endif
      return mem[a];
   endfunction

   function automatic logic m_pend(input int a, input bit we, input int wa);
      if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (we && wa == a) return 1'b0;
`endif
      return pnd[a];
   endfunction

   // One clock of stimulus: drive, queue the expected outputs, advance the model.
   task automatic cycle(input bit r, input bit we, input int wa, input logic [31:0] wd,
                        input bit iv, input int ia, input bit fl,
                        input int ra0, input int ra1, input bit chk);
      exp_t e;
      int   n;
      bit   rdy;
      @(posedge clk);
      #1;
      rst = r; wr_en = we; wr_addr = 5'(wa); wr_data = wd;
      iss_valid = iv; iss_addr = 5'(ia); flush = fl;
      rd_addr = {5'(ra1), 5'(ra0)};
      rdy = (ia == 0) || !pnd[ia] || (we && wa == ia);
      n = 0;
      for (int i = 0; i < 32; i++) if (pnd[i]) n++;
      e.d0  = m_data(ra0, we, wa, wd);
      e.d1  = m_data(ra1, we, wa, wd);
      e.p   = {m_pend(ra1, we, wa), m_pend(ra0, we, wa)};
      e.rdy = rdy;
      e.cnt = 6'(n);
      if (chk) exp_q.push_back(e);
      if (r) begin
         for (int i = 0; i < 32; i++) begin mem[i] = 32'h0; pnd[i] = 1'b0; end
      end else begin
         if (we && wa != 0) begin mem[wa] = wd; pnd[wa] = 1'b0; end
         if (fl) begin
            for (int i = 0; i < 32; i++) pnd[i] = 1'b0;
         end else if (iv && rdy && ia != 0) begin
            pnd[ia] = 1'b1;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: every falling edge with a queued expectation is compared to the DUT.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rd_data0", rd_data[31:0], e.d0);
            check("rd_data1", rd_data[63:32], e.d1);
            check("rd_pend", 32'(rd_pend), 32'(e.p));
            check("iss_ready", 32'(iss_ready), 32'(e.rdy));
            check("pend_cnt", 32'(pend_cnt), 32'(e.cnt));
         end
      end
   end

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      iss_valid = 1'b0; iss_addr = '0; flush = 1'b0; rd_addr = '0;
      for (int i = 0; i < 32; i++) begin mem[i] = 'x; pnd[i] = 1'b0; end

      // Initial reset: outputs are undefined until the first reset edge.
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      // Sweep all registers on both ports after reset.
      for (int i = 0; i < 32; i++) cycle(0, 0, 0, 0, 0, i, 0, i, 31 - i, 1);
      // Plain write/read and write to x0.
      cycle(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 5, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 5, 5, 1);
      cycle(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      // RAW/WAW: issue x7, re-issue blocked, then re-issue alongside its writeback.
      cycle(0, 0, 0, 0, 1, 7, 0, 7, 7, 1);
      cycle(0, 0, 0, 0, 1, 7, 0, 7, 7, 1);
      cycle(0, 1, 7, 32'h12, 1, 7, 0, 7, 7, 1);
      cycle(0, 0, 0, 0, 0, 7, 0, 7, 7, 1);
      // Flush with a concurrent write.
      cycle(0, 0, 0, 0, 1, 1, 0, 1, 2, 1);
      cycle(0, 0, 0, 0, 1, 2, 0, 1, 2, 1);
      cycle(0, 0, 0, 0, 1, 3, 0, 3, 7, 1);
      cycle(0, 1, 4, 32'h55, 1, 6, 1, 1, 3, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 4, 7, 1);
      // Write to x9 while reading it: bypass decides same-cycle visibility.
      cycle(0, 1, 9, 32'h1111, 0, 0, 0, 0, 9, 1);
      cycle(0, 1, 9, 32'hA5A5, 1, 9, 0, 0, 9, 1);
      cycle(0, 0, 0, 0, 0, 9, 0, 9, 9, 1);
      // Reset wins over concurrent issue and write.
      cycle(0, 1, 3, 32'h7, 1, 3, 0, 3, 3, 1);
      cycle(1, 1, 3, 32'h1, 1, 3, 0, 3, 3, 1);
      cycle(0, 0, 0, 0, 0, 3, 0, 3, 3, 1);

      // Random traffic, biased toward a few registers to create hazards.
      for (int c = 0; c < 3000; c++) begin
         bit r, we, iv, fl;
         int wa, ia, r0, r1;
         r  = ($urandom_range(0, 99) == 0);
         fl = ($urandom_range(0, 19) == 0);
         we = ($urandom_range(0, 2) == 0);
         iv = ($urandom_range(0, 1) == 0);
         wa = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
         ia = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
         r0 = ($urandom_range(0, 1) == 0) ? wa : $urandom_range(0, 31);
         r1 = ($urandom_range(0, 1) == 0) ? ia : $urandom_range(0, 31);
         cycle(r, we, wa, $urandom, iv, ia, fl, r0, r1, 1);
      end

      // Drain: the monitor must consume everything within a few cycles.
      repeat (3) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain actual=%0d required=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
